// File: rtl/universal_register.sv
// ---------------------------------------------------------------------------
// universal_register
//   WIDTH-bit state register with clock enable and synchronous reset. Eight
//   operating modes: hold, parallel load, shift left/right, rotate left/right
//   and count up/down. Intended as a datapath building block for counters,
//   serialisers and accumulators.
//
// Parameters
//   WIDTH    register width in bits (>= 2)
//   RST_VAL  value loaded into PO on reset
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous reset, active-high (wins over cen)
//   cen    in   1      clock enable; register updates only when 1
//   mode   in   3      operation select
//   PI     in   WIDTH  parallel load data
//   sin_r  in   1      serial in, enters PO[0] on shift left
//   sin_l  in   1      serial in, enters PO[WIDTH-1] on shift right
//   PO     out  WIDTH  register contents
//   sout   out  1      serial out (combinational from PO and mode)
//   tc     out  1      terminal count (combinational from PO, mode and cen)
//
// Configuration macro
//   UREG_SAT_EN  when defined, the count modes saturate at all ones (up) and
//                at zero (down) instead of wrapping modulo 2^WIDTH.
// ---------------------------------------------------------------------------
module universal_register #(
  parameter int                 WIDTH   = 4,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] PI,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] PO,
  output logic             sout,
  output logic             tc
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_UP   = 3'b110,
    MODE_DOWN = 3'b111
  } mode_e;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_po;
  logic [WIDTH-1:0] w_next;
  logic             w_allOnes;
  logic             w_zero;
  mode_e            w_mode;

  assign w_mode    = mode_e'(mode);
  assign w_allOnes = &r_po;
  assign w_zero    = ~|r_po;

  // Next-state selection for an enabled edge. Reset and enable are applied
  // in the sequential block so this only describes the mode operation.
  always_comb begin
    w_next = r_po;
    case (w_mode)
      MODE_HOLD: w_next = r_po;
      MODE_LOAD: w_next = PI;
      MODE_SHL:  w_next = {r_po[WIDTH-2:0], sin_r};
      MODE_SHR:  w_next = {sin_l, r_po[WIDTH-1:1]};
      MODE_ROL:  w_next = {r_po[WIDTH-2:0], r_po[WIDTH-1]};
      MODE_ROR:  w_next = {r_po[0], r_po[WIDTH-1:1]};
`ifdef UREG_SAT_EN
      // Saturating counter: stick at the limit instead of wrapping.
      MODE_UP:   w_next = w_allOnes ? r_po : r_po + ONE;
      MODE_DOWN: w_next = w_zero    ? r_po : r_po - ONE;
`else
      // Wrapping counter: natural modulo 2^WIDTH arithmetic.
      MODE_UP:   w_next = r_po + ONE;
      MODE_DOWN: w_next = r_po - ONE;
`endif
      default:   w_next = r_po;
    endcase
  end

  // State register: reset has priority over the clock enable, and a pending
  // mode operation is discarded whenever reset is asserted at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_po <= RST_VAL;
    end else if (cen) begin
      r_po <= w_next;
    end
  end

  // Serial out shows the bit that is about to leave the register in the
  // current shift/rotate direction; it is 0 in the non-serial modes.
  always_comb begin
    sout = 1'b0;
    case (w_mode)
      MODE_SHL, MODE_ROL: sout = r_po[WIDTH-1];
      MODE_SHR, MODE_ROR: sout = r_po[0];
      default:            sout = 1'b0;
    endcase
  end

  // Terminal count flags the cycle before a wrap (or the held limit when
  // saturating), only while the register is actually enabled.
  assign tc = cen & (((w_mode == MODE_UP)   & w_allOnes) |
                     ((w_mode == MODE_DOWN) & w_zero));

  assign PO = r_po;

endmodule

// File: tb/tb_universal_register.sv
// ---------------------------------------------------------------------------
// tb_universal_register
//   Self-checking bench for universal_register (WIDTH=4). Two instances share
//   every input: one with RST_VAL=0 and one with RST_VAL=5, so the reset
//   value is exercised alongside the normal datapath. A reference model runs
//   beside them; expected register values are queued when stimulus is driven
//   and popped after the following rising edge.
// ---------------------------------------------------------------------------
module tb_universal_register;

  logic       clk;
  logic       rst;
  logic       cen;
  logic [2:0] mode;
  logic [3:0] PI;
  logic       sin_r;
  logic       sin_l;
  logic [3:0] po0;
  logic [3:0] po5;
  logic       sout0;
  logic       sout5;
  logic       tc0;
  logic       tc5;

  int compareCount  = 0;
  int mismatchCount = 0;

  // Reference state for each instance.
  logic [3:0] mdl0;
  logic [3:0] mdl5;

  typedef struct {
    string      tag;
    logic [3:0] exp0;
    logic [3:0] exp5;
  } exp_t;

  exp_t sbQ[$];

  universal_register #(.WIDTH(4), .RST_VAL(4'd0)) dut0 (
    .clk   (clk),
    .rst   (rst),
    .cen   (cen),
    .mode  (mode),
    .PI    (PI),
    .sin_r (sin_r),
    .sin_l (sin_l),
    .PO    (po0),
    .sout  (sout0),
    .tc    (tc0)
  );

  universal_register #(.WIDTH(4), .RST_VAL(4'd5)) dut5 (
    .clk   (clk),
    .rst   (rst),
    .cen   (cen),
    .mode  (mode),
    .PI    (PI),
    .sin_r (sin_r),
    .sin_l (sin_l),
    .PO    (po5),
    .sout  (sout5),
    .tc    (tc5)
  );

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference next-state, written from the mode table.
  function automatic logic [3:0] modelNext(input logic [3:0] cur, input logic [3:0] rv,
                                           input logic r, input logic c, input logic [2:0] m,
                                           input logic [3:0] pi, input logic sr, input logic sl);
    logic [3:0] nx;
    if (r)       return rv;
    if (!c)      return cur;
    case (m)
      3'd0: nx = cur;
      3'd1: nx = pi;
      3'd2: nx = {cur[2:0], sr};
      3'd3: nx = {sl, cur[3:1]};
      3'd4: nx = {cur[2:0], cur[3]};
      3'd5: nx = {cur[0], cur[3:1]};
`ifdef UREG_SAT_EN
      3'd6: nx = (cur == 4'hF) ? cur : cur + 4'd1;
      3'd7: nx = (cur == 4'h0) ? cur : cur - 4'd1;
`else
      3'd6: nx = cur + 4'd1;
      3'd7: nx = cur - 4'd1;
`endif
      default: nx = cur;
    endcase
    return nx;
  endfunction

  function automatic logic modelSout(input logic [3:0] cur, input logic [2:0] m);
    if (m == 3'd2 || m == 3'd4) return cur[3];
    if (m == 3'd3 || m == 3'd5) return cur[0];
    return 1'b0;
  endfunction

  function automatic logic modelTc(input logic [3:0] cur, input logic c, input logic [2:0] m);
    return c && ((m == 3'd6 && cur == 4'hF) || (m == 3'd7 && cur == 4'h0));
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    compareCount++;
    if (obs !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge, check the combinational
  // outputs against the model, queue the expected register value, then pop
  // and compare it just after the rising edge. With glitch set, rst pulses
  // and PI holds a different value briefly before the final values settle.
  task automatic applyStimulus(input string tag, input logic r, input logic c,
                               input logic [2:0] m, input logic [3:0] pi,
                               input logic sr, input logic sl, input logic glitch);
    exp_t e;
    @(negedge clk);
    if (glitch) begin
      rst = 1'b1;
      PI  = ~pi;
      #2;
    end
    rst   = r;
    cen   = c;
    mode  = m;
    PI    = pi;
    sin_r = sr;
    sin_l = sl;
    #1;
    checkOutput({tag, ".sout0"}, {3'b0, sout0}, {3'b0, modelSout(mdl0, m)});
    checkOutput({tag, ".sout5"}, {3'b0, sout5}, {3'b0, modelSout(mdl5, m)});
    checkOutput({tag, ".tc0"},   {3'b0, tc0},   {3'b0, modelTc(mdl0, c, m)});
    checkOutput({tag, ".tc5"},   {3'b0, tc5},   {3'b0, modelTc(mdl5, c, m)});
    mdl0   = modelNext(mdl0, 4'd0, r, c, m, pi, sr, sl);
    mdl5   = modelNext(mdl5, 4'd5, r, c, m, pi, sr, sl);
    e.tag  = tag;
    e.exp0 = mdl0;
    e.exp5 = mdl5;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    if (sbQ.size() == 0) begin
      checkOutput({tag, ".queue"}, 4'd0, 4'd1);
    end else begin
      e = sbQ.pop_front();
      checkOutput({e.tag, ".po0"}, po0, e.exp0);
      checkOutput({e.tag, ".po5"}, po5, e.exp5);
    end
  endtask

  initial begin
    rst   = 1'b1;
    cen   = 1'b0;
    mode  = 3'd0;
    PI    = 4'd0;
    sin_r = 1'b0;
    sin_l = 1'b0;
    mdl0  = 4'd0;
    mdl5  = 4'd0;

    // Reset state.
    applyStimulus("reset",      1, 0, 3'd0, 4'd0,  0, 0, 0);

    // Load and enable.
    applyStimulus("ld_cen0",    0, 0, 3'd1, 4'd12, 0, 0, 0);
    applyStimulus("ld_cen1",    0, 1, 3'd1, 4'd12, 0, 0, 0);
    applyStimulus("ld_hold",    0, 0, 3'd1, 4'd14, 0, 0, 0);

    // Shifts and rotates from 9.
    applyStimulus("ld9a",       0, 1, 3'd1, 4'd9,  0, 0, 0);
    applyStimulus("shl",        0, 1, 3'd2, 4'd0,  1, 0, 0);
    applyStimulus("ld9b",       0, 1, 3'd1, 4'd9,  0, 0, 0);
    applyStimulus("shr",        0, 1, 3'd3, 4'd0,  0, 1, 0);
    applyStimulus("ld9c",       0, 1, 3'd1, 4'd9,  0, 0, 0);
    applyStimulus("rol",        0, 1, 3'd4, 4'd0,  0, 0, 0);
    applyStimulus("ld9d",       0, 1, 3'd1, 4'd9,  0, 0, 0);
    applyStimulus("ror",        0, 1, 3'd5, 4'd0,  0, 0, 0);

    // Count up across the top, then down across zero.
    applyStimulus("ld14",       0, 1, 3'd1, 4'd14, 0, 0, 0);
    applyStimulus("up1",        0, 1, 3'd6, 4'd0,  0, 0, 0);
    applyStimulus("up2",        0, 1, 3'd6, 4'd0,  0, 0, 0);
    applyStimulus("up3",        0, 1, 3'd6, 4'd0,  0, 0, 0);
    applyStimulus("up_cen0",    0, 0, 3'd6, 4'd0,  0, 0, 0);
    applyStimulus("ld1",        0, 1, 3'd1, 4'd1,  0, 0, 0);
    applyStimulus("dn1",        0, 1, 3'd7, 4'd0,  0, 0, 0);
    applyStimulus("dn2",        0, 1, 3'd7, 4'd0,  0, 0, 0);
    applyStimulus("ld15",       0, 1, 3'd1, 4'd15, 0, 0, 0);
    applyStimulus("upTop_cen0", 0, 0, 3'd6, 4'd0,  0, 0, 0);
    applyStimulus("upTop",      0, 1, 3'd6, 4'd0,  0, 0, 0);

    // Reset priority, with cen toggling, then release.
    applyStimulus("ld7",        0, 1, 3'd1, 4'd7,  0, 0, 0);
    applyStimulus("rstCen1",    1, 1, 3'd6, 4'd0,  0, 0, 0);
    applyStimulus("rstCen0",    1, 0, 3'd6, 4'd0,  0, 0, 0);
    applyStimulus("rstRel",     0, 1, 3'd6, 4'd0,  0, 0, 0);

    // Reset and PI glitches between edges must not reach the register.
    applyStimulus("rstGlitch",  0, 0, 3'd0, 4'd3,  0, 0, 1);
    applyStimulus("rstGlitch1", 0, 1, 3'd6, 4'd3,  0, 0, 1);
    applyStimulus("piGlitch",   0, 1, 3'd1, 4'd10, 0, 0, 1);

    // Random mix of all modes.
    for (int i = 0; i < 40; i++) begin
      applyStimulus($sformatf("rnd%0d", i),
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
                    3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
